// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_state_t       : sequencer FSM states
//   DEF_RESET_VECTOR : default first fetch address after reset
//   DEF_TRAP_VECTOR  : default fetch address after any trap
//   DEF_STEP         : default sequential PC increment in bytes
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned DEF_STEP         = 4;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: offers a fetch address, waits for the
// instruction to complete, then selects the next PC (trap, redirect or
// sequential) and counts retired instructions.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   pc_ready          : instruction memory accepts pc (FETCH handshake)
//   advance           : current instruction completed (honoured in EXEC only)
//   redirect_valid    : taken branch/jump for the completing instruction
//   redirect_target   : taken branch/jump target
//   trap_req          : completing instruction raised an exception
//   pc / pc_valid     : current fetch address and its valid flag
//   misalign          : one-cycle pulse on a misaligned redirect
//   retired           : 64-bit count of instructions completed without trap
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int unsigned     STEP         = DEF_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_ready,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign,
  output logic [63:0]     retired
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [63:0]     retired_q, retired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    retired_d  = retired_q;
    pc_valid   = 1'b0;
    unique case (state_q)
      BOOT: begin
        pc_d    = RESET_VECTOR;
        state_d = FETCH;
      end
      FETCH: begin
        pc_valid = 1'b1;
        if (pc_ready) state_d = EXEC;
      end
      EXEC: begin
        // Redirect/trap inputs only matter on the advance cycle.
        if (advance) begin
          if (trap_req) begin
            pc_d    = TRAP_VECTOR;
            state_d = TRAP;
          end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else if (redirect_valid) begin
            pc_d      = redirect_target;
            retired_d = retired_q + 64'd1;
            state_d   = FETCH;
          end else begin
            pc_d      = pc_q + XLEN'(STEP);
            retired_d = retired_q + 64'd1;
            state_d   = FETCH;
          end
        end
      end
      TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc       = pc_q;
  assign misalign = misalign_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_ready, advance, redirect_valid, trap_req;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        pc_valid, misalign;
  logic [63:0] retired;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR(32'h0000_0100),
    .STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_ready(pc_ready),
    .advance(advance),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .trap_req(trap_req),
    .pc(pc),
    .pc_valid(pc_valid),
    .misalign(misalign),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        adv;
    logic        rv;
    logic [31:0] tgt;
    logic        trap;
    logic        cpc;   // compare pc on this row
    logic [31:0] epc;
    logic        ev;
    logic        em;
    logic [63:0] eret;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic ev,
                           input logic em, input logic [63:0] eret, input logic cpc);
    if (cpc) check({tag, ".pc"}, 64'(pc), 64'(epc));
    check({tag, ".pc_valid"}, 64'(pc_valid), 64'(ev));
    check({tag, ".misalign"}, 64'(misalign), 64'(em));
    check({tag, ".retired"}, retired, eret);
  endtask

  initial begin
    //             rdy  adv  rv   tgt            trap cpc  epc            ev   em   ret
    tbl.push_back('{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0000,1'b1,1'b0,64'd0}); // BOOT->FETCH
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0000,1'b0,1'b0,64'd0}); // ->EXEC
    tbl.push_back('{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,32'h0000_0004,1'b1,1'b0,64'd1}); // seq
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0004,1'b0,1'b0,64'd1});
    tbl.push_back('{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,32'h0000_0008,1'b1,1'b0,64'd2});
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0008,1'b0,1'b0,64'd2}); // EXEC @0x8
    tbl.push_back('{1'b0,1'b1,1'b1,32'h40,       1'b0,1'b1,32'h0000_0040,1'b1,1'b0,64'd3}); // redirect 0x40
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0040,1'b0,1'b0,64'd3});
    tbl.push_back('{1'b0,1'b1,1'b1,32'h42,       1'b0,1'b0,32'h0,        1'b0,1'b1,64'd3}); // misaligned -> TRAP
    tbl.push_back('{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0100,1'b1,1'b0,64'd3}); // FETCH trap vec
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0100,1'b0,1'b0,64'd3});
    tbl.push_back('{1'b0,1'b1,1'b1,32'h40,       1'b1,1'b0,32'h0,        1'b0,1'b0,64'd3}); // trap beats redirect
    tbl.push_back('{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0100,1'b1,1'b0,64'd3});
    for (int i = 0; i < 5; i++)                                                              // stall, advance ignored
      tbl.push_back('{1'b0,1'b1,1'b1,32'h42,     1'b1,1'b1,32'h0000_0100,1'b1,1'b0,64'd3});
    tbl.push_back('{1'b1,1'b1,1'b1,32'h40,       1'b0,1'b1,32'h0000_0100,1'b0,1'b0,64'd3}); // accept, adv ignored
    tbl.push_back('{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,32'h0000_0104,1'b1,1'b0,64'd4});
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0104,1'b0,1'b0,64'd4});
    tbl.push_back('{1'b0,1'b1,1'b1,32'hFFFF_FFFC,1'b0,1'b1,32'hFFFF_FFFC,1'b1,1'b0,64'd5});
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,64'd5});
    tbl.push_back('{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,32'h0000_0000,1'b1,1'b0,64'd6}); // wraps to 0
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0000,1'b0,1'b0,64'd6});
    tbl.push_back('{1'b0,1'b1,1'b1,32'h20,       1'b0,1'b1,32'h0000_0020,1'b1,1'b0,64'd7});
    tbl.push_back('{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h0000_0020,1'b0,1'b0,64'd7}); // EXEC @0x20

    rst = 1'b1; pc_ready = 1'b0; advance = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; trap_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 1'b0, 1'b0, 64'd0, 1'b1);
    rst = 1'b0;

    foreach (tbl[i]) begin
      pc_ready        = tbl[i].rdy;
      advance         = tbl[i].adv;
      redirect_valid  = tbl[i].rv;
      redirect_target = tbl[i].tgt;
      trap_req        = tbl[i].trap;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].ev, tbl[i].em, tbl[i].eret, tbl[i].cpc);
    end

    // Asynchronous reset in EXEC at pc=0x20, observed before the next edge.
    pc_ready = 1'b0; advance = 1'b1; redirect_valid = 1'b0; trap_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 1'b0, 1'b0, 64'd0, 1'b1);
    // Held reset over an edge with advance asserted: nothing retires.
    @(posedge clk);
    #1;
    check_all("rst_hold", 32'h0, 1'b0, 1'b0, 64'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0; advance = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst_fetch", 32'h0, 1'b1, 1'b0, 64'd0, 1'b1);

    // Misalign pulse lasts exactly one cycle.
    pc_ready = 1'b1;
    @(posedge clk); #1;
    pc_ready = 1'b0; advance = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0042;
    @(posedge clk); #1;
    check("mis_pulse", 64'(misalign), 64'd1);
    advance = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    check("mis_drop", 64'(misalign), 64'd0);
    check_all("mis_fetch", 32'h0000_0100, 1'b1, 1'b0, 64'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, fetch address after any trap.
REQ-004 SHALL have parameter STEP, default 4, sequential PC increment in bytes.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port pc_ready, input, 1, instruction memory accepts the presented pc.
REQ-008 SHALL have port advance, input, 1, current instruction completed; select next PC.
REQ-009 SHALL have port redirect_valid, input, 1, branch/jump taken for the completing instruction.
REQ-010 SHALL have port redirect_target, input, XLEN, taken-branch/jump target.
REQ-011 SHALL have port trap_req, input, 1, completing instruction raised an exception.
REQ-012 SHALL have port pc, output, XLEN, current fetch address.
REQ-013 SHALL have port pc_valid, output, 1, pc is offered for fetch.
REQ-014 SHALL have port misalign, output, 1, one-cycle pulse on a misaligned redirect.
REQ-015 SHALL have port retired, output, 64, count of instructions completed without a trap.

Function
REQ-016 SHALL implement FSM states BOOT, FETCH, EXEC and TRAP.
REQ-017 BOOT: pc_valid=0, pc=RESET_VECTOR; unconditionally goes to FETCH next cycle.
REQ-018 FETCH: pc_valid=1, pc held stable; on pc_ready=1 goes to EXEC, else stays in FETCH.
REQ-019 EXEC: pc_valid=0, pc held; waits for advance=1; advance in any other state SHALL be ignored.
REQ-020 On advance in EXEC, priority: trap_req, then misaligned redirect, then aligned redirect, then sequential.
REQ-021 trap_req=1: go to TRAP; retired unchanged.
REQ-022 Misaligned redirect (redirect_valid=1, redirect_target[1:0]!=0): treated as trap, go to TRAP, misalign=1 for exactly that cycle.
REQ-023 Aligned redirect: pc<=redirect_target, go to FETCH, retired+1.
REQ-024 Sequential: pc<=pc+STEP modulo 2^XLEN (0xFFFF_FFFC+4 -> 0x0), go to FETCH, retired+1.
REQ-025 TRAP: pc<=TRAP_VECTOR, pc_valid=0, one bubble cycle, then FETCH.
REQ-026 redirect_valid, redirect_target and trap_req SHALL be sampled only in the cycle advance=1 in EXEC.
REQ-027 retired SHALL wrap from 2^64-1 to 0 without any flag.
REQ-028 Each accepted instruction SHALL take at least 2 cycles (FETCH handshake plus EXEC with advance).

Reset
REQ-029 rst=1 SHALL immediately force state=BOOT, pc=RESET_VECTOR, pc_valid=0, misalign=0, retired=0, regardless of clk.
REQ-030 Reset asserted mid-FETCH or mid-EXEC SHALL discard the pending instruction with no retired increment.
REQ-031 After rst deasserts, the first rising edge SHALL move BOOT->FETCH.

Structure
REQ-032 Package pc_pkg SHALL hold pc_state_t (BOOT, FETCH, EXEC, TRAP), default RESET_VECTOR, TRAP_VECTOR and STEP constants.
REQ-033 No sub-module required; next-PC selection SHALL be combinational logic inside pc_sequencer.

Verification
REQ-034 Reset then pc_ready=1 and advance=1 each EXEC for 3 instructions -> pc 0x0,0x4,0x8,0xC; retired=3.
REQ-035 In EXEC at pc=0x8, advance with redirect_valid=1, target=0x40 -> next FETCH pc=0x40; retired+1.
REQ-036 advance with redirect target 0x42 -> misalign pulse 1 cycle, TRAP, then FETCH pc=0x100; retired unchanged.
REQ-037 advance with trap_req=1 and redirect_valid=1, target=0x40 -> trap wins; FETCH pc=0x100; misalign=0.
REQ-038 Hold pc_ready=0 for 5 cycles in FETCH -> pc and pc_valid=1 stable; advance pulses ignored.
REQ-039 Assert rst asynchronously mid-EXEC at pc=0x20 -> pc=0x0, pc_valid=0, retired=0 before the next clk edge.
